// File: rtl/ctrl_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_unit_mc
// Purpose  : Multicycle control FSM for a MIPS-subset datapath
//            (add/sub/and, addi, lw, sw, beq, bne, j). Decodes the instruction
//            fields and ALU flags into mux selects, load enables, the memory
//            write strobe and the ALU operation. Invalid opcodes and
//            arithmetic overflow save PC-4 to EPC and redirect the PC to a
//            vector byte fetched from memory address 253/254.
// Params   : MEM_WAIT - extra cycles (0..3) before memory read data is valid
// Ports    : clk, reset (async, active-high)
//            opcode, funct         - instruction fields from IR
//            alu_overflow, alu_zero- ALU status flags
//            pc_write .. epc_write - register load enables / memory strobe
//            iord, excause, wr_reg, wd_reg, alusrc_a, alusrc_b, alu_op,
//            pc_source, sign_ex_ctrl - datapath selects
//            state_dbg             - current state code
//            instr_count           - retired-instruction counter (only when
//                                    CTRL_INSTR_COUNT_EN is defined)
// Option   : `define CTRL_INSTR_COUNT_EN to add the instr_count output
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_unit_mc #(
    parameter int MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_write,
    output logic        reg_write,
    output logic        load_ab,
    output logic        aluout_load,
    output logic        epc_write,
    output logic [2:0]  iord,
    output logic [1:0]  excause,
    output logic [2:0]  wr_reg,
    output logic [3:0]  wd_reg,
    output logic [2:0]  alusrc_a,
    output logic [2:0]  alusrc_b,
    output logic [2:0]  alu_op,
    output logic [2:0]  pc_source,
    output logic        sign_ex_ctrl,
`ifdef CTRL_INSTR_COUNT_EN
    output logic [31:0] instr_count,
`endif
    output logic [4:0]  state_dbg
);

    typedef enum logic [4:0] {
        S_RST      = 5'd0,
        S_FETCH    = 5'd1,
        S_F_WAIT   = 5'd2,
        S_IR_LOAD  = 5'd3,
        S_DECODE   = 5'd4,
        S_EXEC_R   = 5'd5,
        S_WB_R     = 5'd6,
        S_ADDI     = 5'd7,
        S_WB_I     = 5'd8,
        S_MEM_ADDR = 5'd9,
        S_LW_READ  = 5'd10,
        S_LW_WAIT  = 5'd11,
        S_LW_WB    = 5'd12,
        S_SW       = 5'd13,
        S_BRANCH   = 5'd14,
        S_JUMP     = 5'd15,
        S_EXC_EPC  = 5'd16,
        S_EXC_READ = 5'd17,
        S_EXC_WAIT = 5'd18,
        S_EXC_LOAD = 5'd19
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;

    localparam logic [1:0] c_CAUSE_OPC = 2'd0;
    localparam logic [1:0] c_CAUSE_OVF = 2'd1;

    // With zero wait states the wait states are skipped entirely.
    localparam bit         c_NO_WAIT   = (MEM_WAIT == 0);
    localparam logic [1:0] c_WAIT_INIT = (MEM_WAIT > 0) ? 2'(MEM_WAIT - 1) : 2'd0;

    state_t     r_state;
    logic [1:0] r_wait_cnt;
    logic [1:0] r_cause;

    logic w_rtype_ok;
    logic w_ovf_trap_r;

    assign w_rtype_ok   = (funct == c_FN_ADD) || (funct == c_FN_SUB) || (funct == c_FN_AND);
    // Only add and sub trap on overflow; and is a logical op.
    assign w_ovf_trap_r = ((funct == c_FN_ADD) || (funct == c_FN_SUB)) && alu_overflow;

    // ------------------------------------------------------------------
    // State register, wait counter and exception cause
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_RST;
            r_wait_cnt <= 2'd0;
            r_cause    <= 2'd0;
        end else begin
            case (r_state)
                S_RST:     r_state <= S_FETCH;
                S_FETCH: begin
                    if (c_NO_WAIT) begin
                        r_state <= S_IR_LOAD;
                    end else begin
                        r_state    <= S_F_WAIT;
                        r_wait_cnt <= c_WAIT_INIT;
                    end
                end
                S_F_WAIT: begin
                    if (r_wait_cnt == 2'd0) r_state <= S_IR_LOAD;
                    else                    r_wait_cnt <= r_wait_cnt - 2'd1;
                end
                S_IR_LOAD: r_state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        c_OP_RTYPE: begin
                            if (w_rtype_ok) begin
                                r_state <= S_EXEC_R;
                            end else begin
                                r_state <= S_EXC_EPC;
                                r_cause <= c_CAUSE_OPC;
                            end
                        end
                        c_OP_ADDI:          r_state <= S_ADDI;
                        c_OP_LW, c_OP_SW:   r_state <= S_MEM_ADDR;
                        c_OP_BEQ, c_OP_BNE: r_state <= S_BRANCH;
                        c_OP_J:             r_state <= S_JUMP;
                        default: begin
                            r_state <= S_EXC_EPC;
                            r_cause <= c_CAUSE_OPC;
                        end
                    endcase
                end
                S_EXEC_R: begin
                    if (w_ovf_trap_r) begin
                        r_state <= S_EXC_EPC;
                        r_cause <= c_CAUSE_OVF;
                    end else begin
                        r_state <= S_WB_R;
                    end
                end
                S_WB_R:    r_state <= S_FETCH;
                S_ADDI: begin
                    if (alu_overflow) begin
                        r_state <= S_EXC_EPC;
                        r_cause <= c_CAUSE_OVF;
                    end else begin
                        r_state <= S_WB_I;
                    end
                end
                S_WB_I:    r_state <= S_FETCH;
                S_MEM_ADDR: begin
                    // Address arithmetic never traps.
                    if (opcode == c_OP_LW) r_state <= S_LW_READ;
                    else                   r_state <= S_SW;
                end
                S_LW_READ: begin
                    if (c_NO_WAIT) begin
                        r_state <= S_LW_WB;
                    end else begin
                        r_state    <= S_LW_WAIT;
                        r_wait_cnt <= c_WAIT_INIT;
                    end
                end
                S_LW_WAIT: begin
                    if (r_wait_cnt == 2'd0) r_state <= S_LW_WB;
                    else                    r_wait_cnt <= r_wait_cnt - 2'd1;
                end
                S_LW_WB:   r_state <= S_FETCH;
                S_SW:      r_state <= S_FETCH;
                S_BRANCH:  r_state <= S_FETCH;
                S_JUMP:    r_state <= S_FETCH;
                S_EXC_EPC: r_state <= S_EXC_READ;
                S_EXC_READ: begin
                    if (c_NO_WAIT) begin
                        r_state <= S_EXC_LOAD;
                    end else begin
                        r_state    <= S_EXC_WAIT;
                        r_wait_cnt <= c_WAIT_INIT;
                    end
                end
                S_EXC_WAIT: begin
                    if (r_wait_cnt == 2'd0) r_state <= S_EXC_LOAD;
                    else                    r_wait_cnt <= r_wait_cnt - 2'd1;
                end
                S_EXC_LOAD: r_state <= S_FETCH;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode. Outputs are forced to 0 while reset is asserted so
    // the RST-state register write cannot occur until reset is released.
    // ------------------------------------------------------------------
    always_comb begin
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        load_ab      = 1'b0;
        aluout_load  = 1'b0;
        epc_write    = 1'b0;
        iord         = 3'd0;
        excause      = 2'd0;
        wr_reg       = 3'd0;
        wd_reg       = 4'd0;
        alusrc_a     = 3'd0;
        alusrc_b     = 3'd0;
        alu_op       = 3'd0;
        pc_source    = 3'd0;
        sign_ex_ctrl = 1'b0;
        state_dbg    = 5'd0;
        if (!reset) begin
            state_dbg = r_state;
            case (r_state)
                S_RST: begin
                    reg_write = 1'b1;
                    wr_reg    = 3'd3;
                    wd_reg    = 4'd2;
                end
                S_FETCH, S_F_WAIT: begin
                    alusrc_b = 3'd1;
                    alu_op   = 3'b001;
                end
                S_IR_LOAD: begin
                    alusrc_b = 3'd1;
                    alu_op   = 3'b001;
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
                S_DECODE: begin
                    load_ab     = 1'b1;
                    aluout_load = 1'b1;
                    alusrc_b    = 3'd3;
                    alu_op      = 3'b001;
                end
                S_EXEC_R: begin
                    alusrc_a    = 3'd1;
                    aluout_load = 1'b1;
                    case (funct)
                        c_FN_ADD: alu_op = 3'b001;
                        c_FN_SUB: alu_op = 3'b010;
                        c_FN_AND: alu_op = 3'b011;
                        default:  alu_op = 3'b000;
                    endcase
                end
                S_WB_R: begin
                    reg_write = 1'b1;
                    wr_reg    = 3'd1;
                end
                S_ADDI, S_MEM_ADDR: begin
                    alusrc_a    = 3'd1;
                    alusrc_b    = 3'd2;
                    alu_op      = 3'b001;
                    aluout_load = 1'b1;
                end
                S_WB_I: reg_write = 1'b1;
                S_LW_READ, S_LW_WAIT: iord = 3'd2;
                S_LW_WB: begin
                    iord      = 3'd2;
                    reg_write = 1'b1;
                    wd_reg    = 4'd1;
                end
                S_SW: begin
                    iord      = 3'd2;
                    mem_write = 1'b1;
                end
                S_BRANCH: begin
                    alusrc_a  = 3'd1;
                    alu_op    = 3'b010;
                    pc_source = 3'd1;
                    pc_write  = (opcode == c_OP_BEQ) ? alu_zero : !alu_zero;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 3'd2;
                end
                S_EXC_EPC: begin
                    alusrc_b  = 3'd1;
                    alu_op    = 3'b010;
                    epc_write = 1'b1;
                    excause   = r_cause;
                end
                S_EXC_READ, S_EXC_WAIT: begin
                    iord    = 3'd1;
                    excause = r_cause;
                end
                S_EXC_LOAD: begin
                    iord         = 3'd1;
                    sign_ex_ctrl = 1'b1;
                    pc_source    = 3'd3;
                    pc_write     = 1'b1;
                    excause      = r_cause;
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_INSTR_COUNT_EN
    // Counts instructions that complete normally; trapped ones never reach
    // these terminal states.
    logic [31:0] r_instr_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_count <= 32'd0;
        end else if (r_state inside {S_WB_R, S_WB_I, S_LW_WB, S_SW, S_BRANCH, S_JUMP}) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign instr_count = r_instr_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_unit_mc
// Purpose  : Self-checking bench for ctrl_unit_mc. Instance A uses
//            MEM_WAIT=1, instance B uses MEM_WAIT=2. Each cycle's expected
//            state and output vector is queued with the stimulus, then
//            popped and compared half a clock later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_unit_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A (MEM_WAIT = 1) ----------------
    logic       rst_a = 1'b1;
    logic [5:0] op_a = 6'd0, fn_a = 6'd0;
    logic       ovf_a = 1'b0, zero_a = 1'b0;
    logic       pcw_a, irw_a, mw_a, rw_a, lab_a, aol_a, epw_a, sx_a;
    logic [2:0] iord_a, wr_a, asa_a, asb_a, aop_a, pcs_a;
    logic [1:0] exc_a;
    logic [3:0] wd_a;
    logic [4:0] st_a;
    logic [31:0] outs_a;

    ctrl_unit_mc #(.MEM_WAIT(1)) dut_a (
        .clk(clk), .reset(rst_a), .opcode(op_a), .funct(fn_a),
        .alu_overflow(ovf_a), .alu_zero(zero_a),
        .pc_write(pcw_a), .ir_write(irw_a), .mem_write(mw_a), .reg_write(rw_a),
        .load_ab(lab_a), .aluout_load(aol_a), .epc_write(epw_a),
        .iord(iord_a), .excause(exc_a), .wr_reg(wr_a), .wd_reg(wd_a),
        .alusrc_a(asa_a), .alusrc_b(asb_a), .alu_op(aop_a), .pc_source(pcs_a),
        .sign_ex_ctrl(sx_a), .state_dbg(st_a)
    );
    assign outs_a = {pcw_a, irw_a, mw_a, rw_a, lab_a, aol_a, epw_a, sx_a,
                     iord_a, exc_a, wr_a, wd_a, asa_a, asb_a, aop_a, pcs_a};

    // ---------------- instance B (MEM_WAIT = 2) ----------------
    logic       rst_b = 1'b1;
    logic [5:0] op_b = 6'd0, fn_b = 6'd0;
    logic       ovf_b = 1'b0, zero_b = 1'b0;
    logic       pcw_b, irw_b, mw_b, rw_b, lab_b, aol_b, epw_b, sx_b;
    logic [2:0] iord_b, wr_b, asa_b, asb_b, aop_b, pcs_b;
    logic [1:0] exc_b;
    logic [3:0] wd_b;
    logic [4:0] st_b;
    logic [31:0] outs_b;

    ctrl_unit_mc #(.MEM_WAIT(2)) dut_b (
        .clk(clk), .reset(rst_b), .opcode(op_b), .funct(fn_b),
        .alu_overflow(ovf_b), .alu_zero(zero_b),
        .pc_write(pcw_b), .ir_write(irw_b), .mem_write(mw_b), .reg_write(rw_b),
        .load_ab(lab_b), .aluout_load(aol_b), .epc_write(epw_b),
        .iord(iord_b), .excause(exc_b), .wr_reg(wr_b), .wd_reg(wd_b),
        .alusrc_a(asa_b), .alusrc_b(asb_b), .alu_op(aop_b), .pc_source(pcs_b),
        .sign_ex_ctrl(sx_b), .state_dbg(st_b)
    );
    assign outs_b = {pcw_b, irw_b, mw_b, rw_b, lab_b, aol_b, epw_b, sx_b,
                     iord_b, exc_b, wr_b, wd_b, asa_b, asb_b, aop_b, pcs_b};

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        logic        ovf;
        logic [1:0]  cause;
        logic [4:0]  st;
        logic [31:0] exp;
    } rec_t;

    rec_t q_a[$];
    rec_t q_b[$];
    int   path[$];
    int   total = 0;
    int   bad   = 0;

    // Reference output table written directly from the state/action list.
    function automatic logic [31:0] model(input rec_t r);
        logic       pcw, irw, mw, rw, lab, aol, epw, sx;
        logic [2:0] io, wr, asa, asb, aop, pcs;
        logic [1:0] exc;
        logic [3:0] wd;
        {pcw, irw, mw, rw, lab, aol, epw, sx} = 8'd0;
        {io, wr, asa, asb, aop, pcs} = 18'd0;
        exc = 2'd0;
        wd  = 4'd0;
        if (!r.rst) begin
            case (r.st)
                5'd0:  begin rw = 1; wr = 3'd3; wd = 4'd2; end
                5'd1, 5'd2: begin asb = 3'd1; aop = 3'b001; end
                5'd3:  begin asb = 3'd1; aop = 3'b001; irw = 1; pcw = 1; end
                5'd4:  begin lab = 1; aol = 1; asb = 3'd3; aop = 3'b001; end
                5'd5:  begin
                    asa = 3'd1; aol = 1;
                    aop = (r.fn == 6'h20) ? 3'b001 : (r.fn == 6'h22) ? 3'b010 : 3'b011;
                end
                5'd6:  begin rw = 1; wr = 3'd1; end
                5'd7, 5'd9: begin asa = 3'd1; asb = 3'd2; aop = 3'b001; aol = 1; end
                5'd8:  rw = 1;
                5'd10, 5'd11: io = 3'd2;
                5'd12: begin io = 3'd2; rw = 1; wd = 4'd1; end
                5'd13: begin io = 3'd2; mw = 1; end
                5'd14: begin
                    asa = 3'd1; aop = 3'b010; pcs = 3'd1;
                    pcw = (r.op == 6'h04) ? r.zero : ~r.zero;
                end
                5'd15: begin pcw = 1; pcs = 3'd2; end
                5'd16: begin asb = 3'd1; aop = 3'b010; epw = 1; exc = r.cause; end
                5'd17, 5'd18: begin io = 3'd1; exc = r.cause; end
                5'd19: begin io = 3'd1; sx = 1; pcs = 3'd3; pcw = 1; exc = r.cause; end
                default: ;
            endcase
        end
        return {pcw, irw, mw, rw, lab, aol, epw, sx, io, exc, wr, wd, asa, asb, aop, pcs};
    endfunction

    // Queue one expectation per entry of path, all sharing the same inputs.
    task automatic push_path(input bit which, input logic rst, input logic [5:0] op,
                             input logic [5:0] fn, input logic zero, input logic ovf,
                             input logic [1:0] cause);
        rec_t r;
        foreach (path[i]) begin
            r.rst = rst; r.op = op; r.fn = fn; r.zero = zero; r.ovf = ovf;
            r.cause = cause; r.st = 5'(path[i]); r.exp = 32'd0;
            r.exp = model(r);
            if (which) q_b.push_back(r);
            else       q_a.push_back(r);
        end
    endtask

    // Apply one record's inputs mid-cycle, then settle before sampling.
    task automatic drive(input bit which, input rec_t r);
        @(negedge clk);
        if (which) begin
            rst_b = r.rst; op_b = r.op; fn_b = r.fn; zero_b = r.zero; ovf_b = r.ovf;
        end else begin
            rst_a = r.rst; op_a = r.op; fn_a = r.fn; zero_a = r.zero; ovf_a = r.ovf;
        end
        #1;
    endtask

    task automatic test_reset;
        rec_t r;
        path = '{0, 0, 0};
        push_path(0, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 2'd0);
        path = '{0};
        push_path(0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 2'd0);
        while (q_a.size() > 0) begin
            r = q_a.pop_front();
            drive(0, r);
            total++;
            if ({st_a, outs_a} !== {r.st, r.exp}) begin
                bad++;
                $display("FAIL reset: state got=%0d want=%0d outs got=%h want=%h", st_a, r.st, outs_a, r.exp);
            end
        end
    endtask

    task automatic test_rtype;
        rec_t r;
        path = '{1, 2, 3, 4, 5, 6};
        push_path(0, 1'b0, 6'h00, 6'h20, 1'b0, 1'b0, 2'd0);   // add
        push_path(0, 1'b0, 6'h00, 6'h24, 1'b0, 1'b1, 2'd0);   // and with overflow flag: no trap
        while (q_a.size() > 0) begin
            r = q_a.pop_front();
            drive(0, r);
            total++;
            if ({st_a, outs_a} !== {r.st, r.exp}) begin
                bad++;
                $display("FAIL rtype: state got=%0d want=%0d outs got=%h want=%h", st_a, r.st, outs_a, r.exp);
            end
        end
    endtask

    task automatic test_branch;
        rec_t r;
        path = '{1, 2, 3, 4, 14};
        push_path(0, 1'b0, 6'h04, 6'h00, 1'b1, 1'b0, 2'd0);   // beq taken
        push_path(0, 1'b0, 6'h04, 6'h00, 1'b0, 1'b0, 2'd0);   // beq not taken
        push_path(0, 1'b0, 6'h05, 6'h00, 1'b1, 1'b0, 2'd0);   // bne not taken
        push_path(0, 1'b0, 6'h05, 6'h00, 1'b0, 1'b0, 2'd0);   // bne taken
        while (q_a.size() > 0) begin
            r = q_a.pop_front();
            drive(0, r);
            total++;
            if ({st_a, outs_a} !== {r.st, r.exp}) begin
                bad++;
                $display("FAIL branch: op=%h zero=%0d state got=%0d want=%0d outs got=%h want=%h",
                         r.op, r.zero, st_a, r.st, outs_a, r.exp);
            end
        end
    endtask

    task automatic test_overflow;
        rec_t r;
        path = '{1, 2, 3, 4, 5, 16, 17, 18, 19};
        push_path(0, 1'b0, 6'h00, 6'h22, 1'b0, 1'b1, 2'd1);   // sub overflows
        while (q_a.size() > 0) begin
            r = q_a.pop_front();
            drive(0, r);
            total++;
            if ({st_a, outs_a} !== {r.st, r.exp}) begin
                bad++;
                $display("FAIL overflow: state got=%0d want=%0d outs got=%h want=%h", st_a, r.st, outs_a, r.exp);
            end
        end
    endtask

    task automatic test_bad_opcode;
        rec_t r;
        path = '{1, 2, 3, 4, 16, 17, 18};
        push_path(0, 1'b0, 6'h3F, 6'h00, 1'b0, 1'b0, 2'd0);
        while (q_a.size() > 0) begin
            r = q_a.pop_front();
            drive(0, r);
            total++;
            if ({st_a, outs_a} !== {r.st, r.exp}) begin
                bad++;
                $display("FAIL bad_opcode: state got=%0d want=%0d outs got=%h want=%h", st_a, r.st, outs_a, r.exp);
            end
        end
        // Reset asserted mid-cycle in EXC_WAIT, before the next clock edge.
        #2 rst_a = 1'b1;
        #1;
        total++;
        if ({st_a, outs_a} !== 37'd0) begin
            bad++;
            $display("FAIL async_reset: state got=%0d want=0 outs got=%h want=0", st_a, outs_a);
        end
        path = '{0};
        push_path(0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 2'd0);
        while (q_a.size() > 0) begin
            r = q_a.pop_front();
            drive(0, r);
            total++;
            if ({st_a, outs_a} !== {r.st, r.exp}) begin
                bad++;
                $display("FAIL reset_release: state got=%0d want=%0d outs got=%h want=%h", st_a, r.st, outs_a, r.exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        rec_t r;
        path = '{1, 2, 3, 4, 7, 8};
        push_path(0, 1'b0, 6'h08, 6'h00, 1'b0, 1'b0, 2'd0);   // addi
        path = '{1, 2, 3, 4, 9, 10, 11, 12};
        push_path(0, 1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 2'd0);   // lw
        path = '{1, 2, 3, 4, 9, 13};
        push_path(0, 1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 2'd0);   // sw, overflow ignored
        path = '{1, 2, 3, 4, 15};
        push_path(0, 1'b0, 6'h02, 6'h00, 1'b0, 1'b0, 2'd0);   // j
        path = '{1, 2, 3, 4, 7, 16, 17, 18, 19};
        push_path(0, 1'b0, 6'h08, 6'h00, 1'b0, 1'b1, 2'd1);   // addi overflow
        path = '{1, 2, 3, 4, 16, 17, 18, 19};
        push_path(0, 1'b0, 6'h00, 6'h25, 1'b0, 1'b0, 2'd0);   // R-type bad funct
        path = '{1, 2, 3, 4, 5, 6, 1};
        push_path(0, 1'b0, 6'h00, 6'h22, 1'b0, 1'b0, 2'd0);   // sub, then refetch
        while (q_a.size() > 0) begin
            r = q_a.pop_front();
            drive(0, r);
            total++;
            if ({st_a, outs_a} !== {r.st, r.exp}) begin
                bad++;
                $display("FAIL back_to_back: op=%h fn=%h state got=%0d want=%0d outs got=%h want=%h",
                         r.op, r.fn, st_a, r.st, outs_a, r.exp);
            end
        end
    endtask

    task automatic test_lw_wait2;
        rec_t r;
        rst_a = 1'b1;
        path = '{0, 1, 2, 2, 3, 4, 9, 10, 11, 11, 12, 1};
        push_path(1, 1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 2'd0);
        while (q_b.size() > 0) begin
            r = q_b.pop_front();
            drive(1, r);
            total++;
            if ({st_b, outs_b} !== {r.st, r.exp}) begin
                bad++;
                $display("FAIL lw_wait2: state got=%0d want=%0d outs got=%h want=%h", st_b, r.st, outs_b, r.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_branch();
        test_overflow();
        test_bad_opcode();
        test_back_to_back();
        test_lw_wait2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
